// File: rtl/backtrack_ctrl_if.sv
// Handshake and trail-stack bundle for backtrack_ctrl.
// master = surrounding solver/stack, slave = the controller.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

interface backtrack_ctrl_if;
  logic                      decide_req;
  logic [`MAX_VARS_BITS-1:0] decide_var;
  logic                      decide_val;
  logic                      imply_req;
  logic [`MAX_VARS_BITS-1:0] imply_var;
  logic                      imply_val;
  logic                      conflict;
  logic                      decide_ack;
  logic                      imply_ack;
  logic                      stk_push;
  logic                      stk_pop;
  logic [`MAX_VARS_BITS-1:0] stk_var_in;
  logic                      stk_val_in;
  logic                      stk_type_in;
  logic [`MAX_VARS_BITS-1:0] stk_var_out;
  logic                      stk_val_out;
  logic                      stk_type_out;
  logic                      stk_empty;
  logic                      stk_full;
  logic                      unassign_valid;
  logic [`MAX_VARS_BITS-1:0] unassign_var;
  logic                      assign_valid;
  logic [`MAX_VARS_BITS-1:0] assign_var;
  logic                      assign_val;
  logic                      busy;
  logic                      unsat;
  logic                      overflow;

  modport master (
    output decide_req, decide_var, decide_val, imply_req, imply_var, imply_val, conflict,
    output stk_var_out, stk_val_out, stk_type_out, stk_empty, stk_full,
    input  decide_ack, imply_ack, stk_push, stk_pop, stk_var_in, stk_val_in, stk_type_in,
    input  unassign_valid, unassign_var, assign_valid, assign_var, assign_val,
    input  busy, unsat, overflow
  );

  modport slave (
    input  decide_req, decide_var, decide_val, imply_req, imply_var, imply_val, conflict,
    input  stk_var_out, stk_val_out, stk_type_out, stk_empty, stk_full,
    output decide_ack, imply_ack, stk_push, stk_pop, stk_var_in, stk_val_in, stk_type_in,
    output unassign_valid, unassign_var, assign_valid, assign_var, assign_val,
    output busy, unsat, overflow
  );
endinterface

// File: rtl/backtrack_ctrl.sv
// Chronological backtracking controller over an external trail stack.
// Optional saturating statistics counters are enabled with macro BT_STATS_EN.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module backtrack_ctrl #(
  parameter int STAT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  backtrack_ctrl_if.slave     bus
`ifdef BT_STATS_EN
  ,
  output logic [STAT_W-1:0]   o_bt_count,
  output logic [STAT_W-1:0]   o_pop_count
`endif
);

  localparam int VW = `MAX_VARS_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLIP  = 2'd2,
    ST_UNSAT = 2'd3
  } state_t;

  state_t          r_state;
  logic [VW-1:0]   r_flip_var;
  logic            r_flip_val;
  logic            r_unsat;
  logic            r_overflow;

  logic            w_push;
  logic            w_pop;
  logic            w_type;
  logic [VW-1:0]   w_var;
  logic            w_val;
  logic            w_dack;
  logic            w_iack;
  logic            w_unassign;
  logic [VW-1:0]   w_uvar;
  logic            w_assign;
  logic            w_ovf;

  if (STAT_W < 1) begin : g_stat_w_invalid
  end

  // Per-cycle stack/handshake pulses; they must react to the live top-of-stack
  // in the same cycle so that one entry can be popped every clock.
  always_comb begin
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_type     = 1'b0;
    w_var      = {VW{1'b0}};
    w_val      = 1'b0;
    w_dack     = 1'b0;
    w_iack     = 1'b0;
    w_unassign = 1'b0;
    w_uvar     = {VW{1'b0}};
    w_assign   = 1'b0;
    w_ovf      = 1'b0;
    if (i_rst) begin
      w_ovf = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.conflict) begin
            w_ovf = 1'b0;
          end else if (bus.imply_req) begin
            if (bus.stk_full) begin
              w_ovf = 1'b1;
            end else begin
              w_push = 1'b1;
              w_type = 1'b1;
              w_var  = bus.imply_var;
              w_val  = bus.imply_val;
              w_iack = 1'b1;
            end
          end else if (bus.decide_req) begin
            if (bus.stk_full) begin
              w_ovf = 1'b1;
            end else begin
              w_push = 1'b1;
              w_type = 1'b0;
              w_var  = bus.decide_var;
              w_val  = bus.decide_val;
              w_dack = 1'b1;
            end
          end else begin
            w_ovf = 1'b0;
          end
        end
        ST_SCAN: begin
          if (!bus.stk_empty) begin
            w_pop      = 1'b1;
            w_unassign = 1'b1;
            w_uvar     = bus.stk_var_out;
          end else begin
            w_pop = 1'b0;
          end
        end
        ST_FLIP: begin
          w_push   = 1'b1;
          w_type   = 1'b1;
          w_var    = r_flip_var;
          w_val    = r_flip_val;
          w_assign = 1'b1;
        end
        default: begin
          w_push = 1'b0;
        end
      endcase
    end
  end

  // Control FSM, flipped-decision latch and sticky status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_flip_var <= {VW{1'b0}};
      r_flip_val <= 1'b0;
      r_unsat    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.conflict) begin
            r_state <= ST_SCAN;
          end
          if (w_ovf) begin
            r_overflow <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (bus.stk_empty) begin
            r_state <= ST_UNSAT;
            r_unsat <= 1'b1;
          end else if (!bus.stk_type_out) begin
            r_flip_var <= bus.stk_var_out;
            r_flip_val <= ~bus.stk_val_out;
            r_state    <= ST_FLIP;
          end
        end
        ST_FLIP: begin
          r_state <= ST_IDLE;
        end
        ST_UNSAT: begin
          r_state <= ST_UNSAT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stk_push       = w_push;
  assign bus.stk_pop        = w_pop;
  assign bus.stk_type_in    = w_type;
  assign bus.stk_var_in     = w_var;
  assign bus.stk_val_in     = w_val;
  assign bus.decide_ack     = w_dack;
  assign bus.imply_ack      = w_iack;
  assign bus.unassign_valid = w_unassign;
  assign bus.unassign_var   = w_uvar;
  assign bus.assign_valid   = w_assign;
  assign bus.assign_var     = w_assign ? r_flip_var : {VW{1'b0}};
  assign bus.assign_val     = w_assign & r_flip_val;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.unsat          = r_unsat;
  assign bus.overflow       = r_overflow;

`ifdef BT_STATS_EN
  logic [STAT_W-1:0] r_bt_count;
  logic [STAT_W-1:0] r_pop_count;

  // Saturating counts of completed flips and of stack pops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bt_count  <= {STAT_W{1'b0}};
      r_pop_count <= {STAT_W{1'b0}};
    end else begin
      if (w_assign && (r_bt_count != {STAT_W{1'b1}})) begin
        r_bt_count <= r_bt_count + STAT_W'(1'b1);
      end
      if (w_pop && (r_pop_count != {STAT_W{1'b1}})) begin
        r_pop_count <= r_pop_count + STAT_W'(1'b1);
      end
    end
  end

  assign o_bt_count  = r_bt_count;
  assign o_pop_count = r_pop_count;
`endif

endmodule
